// File: rtl/io_tile_pkg.sv
// Shared types and constants for the bottom-edge I/O tile.
// Pad mode field positions and the packed per-pad config view.
package io_tile_pkg;

    localparam int CFG_W   = 3;
    localparam int CFG_EN  = 0;
    localparam int CFG_DIR = 1;
    localparam int CFG_INV = 2;

    typedef struct packed {
        logic inv;
        logic dir;
        logic en;
    } pad_cfg_t;

    // Unpack one pad's slice of the shadow register into named fields.
    function automatic pad_cfg_t to_pad_cfg(input logic [CFG_W-1:0] bits);
        pad_cfg_t cfg;
        cfg.en  = bits[CFG_EN];
        cfg.dir = bits[CFG_DIR];
        cfg.inv = bits[CFG_INV];
        return cfg;
    endfunction

endpackage

// File: rtl/io_pad_cell.sv
// Combinational datapath for a single pad subtile.
// Isolation or a disabled pad forces every output low.
module io_pad_cell
    import io_tile_pkg::*;
(
    input  pad_cfg_t cfg_i,
    input  logic     isol_n_i,
    input  logic     outpad_i,
    input  logic     soc_in_i,
    output logic     soc_out_o,
    output logic     soc_dir_o,
    output logic     inpad_o
);

    logic act_s;

    assign act_s     = isol_n_i & cfg_i.en;
    assign soc_dir_o = act_s & cfg_i.dir;
    assign soc_out_o = act_s & cfg_i.dir & (outpad_i ^ cfg_i.inv);
    assign inpad_o   = act_s & ~cfg_i.dir & (soc_in_i ^ cfg_i.inv);

endmodule

// File: rtl/io_tile_bottom_array.sv
// Bottom-edge I/O tile: serial config chain, shadow commit with length check,
// and NUM_PADS combinational pad cells driven from the shadow.
module io_tile_bottom_array
    import io_tile_pkg::*;
#(
    parameter int NUM_PADS = 2
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                IO_ISOL_N,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_load,
    output logic                ccff_tail,
    input  logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN,
    output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT,
    output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR,
    input  logic [NUM_PADS-1:0] pin_outpad,
    output logic [NUM_PADS-1:0] pin_inpad,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int TOTAL = NUM_PADS * CFG_W;
    localparam int CNT_W = $clog2(TOTAL + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);

    logic [TOTAL-1:0] sr_q, sr_d;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // Next state: commit samples the pre-shift chain and pre-increment count.
    always_comb begin
        sr_d     = sr_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;

        if (ccff_en) begin
            sr_d = {sr_q[TOTAL-2:0], ccff_head};
        end else begin
            sr_d = sr_q;
        end

        if (ccff_load) begin
            if (cnt_q == CNT_FULL) begin
                shadow_d = sr_q;
                valid_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = ccff_en ? CNT_W'(1) : CNT_W'(0);
        end else if (ccff_en && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Chain, shadow, counter and status registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            sr_q     <= {TOTAL{1'b0}};
            shadow_q <= {TOTAL{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ccff_tail = sr_q[TOTAL-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        io_pad_cell u_pad (
            .cfg_i     (to_pad_cfg(shadow_q[i*CFG_W +: CFG_W])),
            .isol_n_i  (IO_ISOL_N),
            .outpad_i  (pin_outpad[i]),
            .soc_in_i  (gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN[i]),
            .soc_out_o (gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT[i]),
            .soc_dir_o (gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR[i]),
            .inpad_o   (pin_inpad[i])
        );
    end

endmodule

// File: tb/tb_io_tile_bottom_array.sv
// Directed bench for io_tile_bottom_array (NUM_PADS=2): a reference model pushes
// expected output bundles to a scoreboard queue, popped and checked after each step.
module tb_io_tile_bottom_array;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       IO_ISOL_N;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_load;
    logic       ccff_tail;
    logic [1:0] soc_in;
    logic [1:0] soc_out;
    logic [1:0] soc_dir;
    logic [1:0] outpad;
    logic [1:0] inpad;
    logic       cfg_valid;
    logic       cfg_err;

    always #5 prog_clk = ~prog_clk;

    io_tile_bottom_array #(.NUM_PADS(2)) dut (
        .prog_clk                            (prog_clk),
        .prog_reset_n                        (prog_reset_n),
        .IO_ISOL_N                           (IO_ISOL_N),
        .ccff_head                           (ccff_head),
        .ccff_en                             (ccff_en),
        .ccff_load                           (ccff_load),
        .ccff_tail                           (ccff_tail),
        .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN  (soc_in),
        .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT (soc_out),
        .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR (soc_dir),
        .pin_outpad                          (outpad),
        .pin_inpad                           (inpad),
        .cfg_valid                           (cfg_valid),
        .cfg_err                             (cfg_err)
    );

    // Reference model state
    logic [5:0] m_sr;
    logic [5:0] m_sh;
    int         m_cnt;
    logic       m_valid;
    logic       m_err;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    // Bundle layout: {soc_out[1:0], soc_dir[1:0], inpad[1:0], tail, valid, err}
    function automatic logic [8:0] model_out();
        logic [1:0] o, d, p;
        logic [2:0] c;
        logic       act;
        for (int i = 0; i < 2; i++) begin
            c    = m_sh[i*3 +: 3];
            act  = IO_ISOL_N & c[0];
            o[i] = act & c[1] & (outpad[i] ^ c[2]);
            d[i] = act & c[1];
            p[i] = act & ~c[1] & (soc_in[i] ^ c[2]);
        end
        return {o, d, p, m_sr[5], m_valid, m_err};
    endfunction

    task automatic model_reset();
        m_sr = 6'd0; m_sh = 6'd0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_model(input string t);
        exp_q.push_back(model_out());
        tag_q.push_back(t);
    endtask

    task automatic push_const(input logic [8:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic check();
        logic [8:0] e, obs;
        string t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {soc_out, soc_dir, inpad, ccff_tail, cfg_valid, cfg_err};
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
    endtask

    // One clocked step; the model advances to the post-edge state before the push.
    task automatic step(input logic head, input logic en, input logic load, input string t);
        @(negedge prog_clk);
        ccff_head = head; ccff_en = en; ccff_load = load;
        if (load) begin
            if (m_cnt == 6) begin m_sh = m_sr; m_valid = 1'b1; end
            else m_err = 1'b1;
        end
        if (load) m_cnt = en ? 1 : 0;
        else if (en && m_cnt < 7) m_cnt++;
        if (en) m_sr = {m_sr[4:0], head};
        push_model(t);
        @(posedge prog_clk);
        #1;
        check();
        ccff_en = 1'b0; ccff_load = 1'b0;
    endtask

    task automatic comb(input string t);
        push_model(t);
        #1;
        check();
    endtask

    task automatic shift_seq(input logic [5:0] bits, input int n, input string t);
        for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1, 1'b0, t);
    endtask

    initial begin
        logic [5:0] cfg_a, cfg_b, cfg_c;
        cfg_a = 6'b101011;
        cfg_b = 6'b111101;
        cfg_c = 6'b010010;

        prog_reset_n = 1'b1; IO_ISOL_N = 1'b1; ccff_head = 1'b0; ccff_en = 1'b0;
        ccff_load = 1'b0; soc_in = 2'b00; outpad = 2'b00;
        #2 prog_reset_n = 1'b0;
        model_reset();
        #1;
        push_const(9'b0, "reset");
        check();
        @(negedge prog_clk);
        prog_reset_n = 1'b1;

        // Test 2: load 1,0,1,0,1,1 -> pad0 output plain, pad1 input inverted
        shift_seq(cfg_a, 6, "shift_a");
        step(1'b0, 1'b0, 1'b1, "load_a");
        outpad = 2'b01; soc_in = 2'b00;
        push_const(9'b01_01_10_1_1_0, "cfg_a_pads");
        #1; check();
        outpad = 2'b00; soc_in = 2'b10;
        comb("cfg_a_pads_flip");
        outpad = 2'b11; soc_in = 2'b01;
        comb("cfg_a_pads_mix");

        // Test 3: isolation
        IO_ISOL_N = 1'b0;
        comb("isol_on");
        step(1'b0, 1'b0, 1'b0, "isol_hold");
        IO_ISOL_N = 1'b1;
        comb("isol_off");

        // Test 4: short load errors, then a full load commits
        shift_seq(6'b001100, 5, "shift_short");
        step(1'b0, 1'b0, 1'b1, "load_short");
        shift_seq(cfg_b, 6, "shift_b");
        step(1'b0, 1'b0, 1'b1, "load_b");
        outpad = 2'b10; soc_in = 2'b00;
        comb("cfg_b_pads");
        outpad = 2'b01; soc_in = 2'b11;
        comb("cfg_b_pads_flip");

        // Test 5: shifting without load leaves pads alone, tail replays old chain
        shift_seq(cfg_c, 6, "shift_noload");
        step(1'b0, 1'b0, 1'b0, "hold_noload");

        // Simultaneous shift and load commits the pre-shift chain (count is 6 here)
        step(1'b1, 1'b1, 1'b1, "load_and_shift");
        step(1'b0, 1'b0, 1'b1, "load_after_one");

        // Test 6: reset mid-shift, then a partial reload errors
        shift_seq(6'b000101, 3, "shift_pre_rst");
        #1 prog_reset_n = 1'b0;
        model_reset();
        comb("rst_async");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        shift_seq(6'b000111, 3, "shift_post_rst");
        step(1'b0, 1'b0, 1'b1, "load_post_rst");
        outpad = 2'b00; soc_in = 2'b00;
        push_const(9'b000000_0_0_1, "post_rst_status");
        #1; check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
